// File: rtl/led_pattern_sequencer_pkg.sv
// led_seq_pkg: shared mode codes, FSM states and
// prescaler width for the LED pattern sequencer.
package led_seq_pkg;

  localparam int ACC_W = 27;

  typedef enum logic [1:0] {
    BLINK    = 2'd0,
    SHIFT    = 2'd1,
    PINGPONG = 2'd2,
    COUNT    = 2'd3
  } mode_t;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

endpackage

// File: rtl/led_pattern_sequencer_tick_gen.sv
// tick_gen: fractional-accumulator prescaler.
// In: clk, rst_n, inc, hold, clear. Out: tick (comb).
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] inc,
  input  logic       hold,
  input  logic       clear,
  output logic       tick
);

  localparam logic [ACC_W:0] DIV_W = (ACC_W+1)'(DIV);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum  = {1'b0, acc} + (ACC_W+1)'(inc);
  assign tick = !hold && (sum >= DIV_W);

  // remainder is kept on wrap so the mean rate is inc/DIV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (!hold) begin
      if (tick) acc <= ACC_W'(sum - DIV_W);
      else      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: switch-driven LED pattern engine.
// In: CLOCK_50, RESET_N, SW[4:0], KEY1_N. Out: LEDR, TICK.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DIV    = 50_000_000,
  parameter int N_LEDS = 10
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [4:0]        SW,
  input  logic              KEY1_N,
  output logic [N_LEDS-1:0] LEDR,
  output logic              TICK
);

  logic [4:0] sw_s1, sw_s2;
  logic       key_s1, key_s2, key_prev;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_prev <= 1'b1;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      key_s1   <= KEY1_N;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

  logic step;
  assign step = key_prev && !key_s2;

  state_t            state;
  mode_t             mode;
  mode_t             new_mode;
  logic              dir_up;
  logic              mode_chg;
  logic              pre_tick;
  logic              advance;
  logic [3:0]        inc;
  logic [N_LEDS-1:0] led_nxt;
  logic              dir_nxt;
  logic [N_LEDS-1:0] reload;

  assign new_mode = mode_t'(sw_s2[3:2]);
  assign mode_chg = (new_mode != mode);
  assign inc      = 4'd1 << sw_s2[1:0];
  assign advance  = (state == RUN) ? pre_tick : step;
  assign reload   = (new_mode == SHIFT || new_mode == PINGPONG)
                  ? N_LEDS'(1) : '0;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .inc   (inc),
    .hold  (state == PAUSED),
    .clear (mode_chg),
    .tick  (pre_tick)
  );

  // pingpong turns around on the advance that lands on an end bit
  always_comb begin
    led_nxt = LEDR;
    dir_nxt = dir_up;
    unique case (1'b1)
      (mode == BLINK): led_nxt = ~LEDR;
      (mode == SHIFT):
        led_nxt = {LEDR[N_LEDS-2:0], LEDR[N_LEDS-1]};
      (mode == PINGPONG): begin
        if (dir_up) begin
          led_nxt = LEDR << 1;
          if (LEDR[N_LEDS-2]) dir_nxt = 1'b0;
        end else begin
          led_nxt = LEDR >> 1;
          if (LEDR[1]) dir_nxt = 1'b1;
        end
      end
      (mode == COUNT): led_nxt = LEDR + N_LEDS'(1);
      default: led_nxt = LEDR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= RUN;
      mode   <= BLINK;
      dir_up <= 1'b1;
      LEDR   <= '0;
      TICK   <= 1'b0;
    end else begin
      unique case (state)
        RUN:     if (sw_s2[4])  state <= PAUSED;
        PAUSED:  if (!sw_s2[4]) state <= RUN;
        default: state <= RUN;
      endcase
      TICK <= 1'b0;
      if (mode_chg) begin
        mode   <= new_mode;
        LEDR   <= reload;
        dir_up <= 1'b1;
      end else if (advance) begin
        LEDR   <= led_nxt;
        dir_up <= dir_nxt;
        TICK   <= 1'b1;
      end
    end
  end

endmodule
